// File: rtl/work_frame_receiver_pkg.sv
// Shared constants and FSM encoding for the work frame receiver.
// Frame layout: 32 bytes of midstate followed by 32 bytes of data2.
package work_frame_receiver_pkg;

    localparam int FRAME_BYTES = 64;
    localparam int WORK_BITS   = 256;
    localparam int SEQ_BITS    = 8;
    localparam int BUF_BITS    = FRAME_BYTES * 8;
    localparam int CNT_BITS    = $clog2(FRAME_BYTES);
    localparam int TIMER_BITS  = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/work_frame_receiver_rx_gap_timer.sv
// Inter-byte gap counter: counts enabled idle cycles and flags when the
// count reaches TIMEOUT_CYCLES-1.
import work_frame_receiver_pkg::*;

module rx_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic hash_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_BITS-1:0] LIMIT = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    logic [TIMER_BITS-1:0] count;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/work_frame_receiver.sv
// Assembles 64-byte work frames from a byte stream and publishes complete
// frames as midstate/data2 with a one-cycle work_valid strobe.
import work_frame_receiver_pkg::*;

module work_frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_data,
    output logic [WORK_BITS-1:0] midstate,
    output logic [WORK_BITS-1:0] data2,
    output logic                 work_valid,
    output logic [SEQ_BITS-1:0]  work_seq,
    output logic                 frame_dropped
);

    state_t                state, state_next;
    logic [CNT_BITS-1:0]   byte_cnt, byte_cnt_next;
    logic [BUF_BITS-1:0]   frame_buf;
    logic                  buf_wr;
    logic [CNT_BITS-1:0]   wr_idx;
    logic                  commit;
    logic                  drop;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .hash_clk (hash_clk),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .expired  (timer_expired)
    );

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        buf_wr        = 1'b0;
        wr_idx        = '0;
        commit        = 1'b0;
        drop          = 1'b0;
        timer_clear   = 1'b1;
        timer_enable  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_ready) begin
                    buf_wr        = 1'b1;
                    byte_cnt_next = CNT_BITS'(1);
                    state_next    = ST_RECV;
                end
            end
            ST_RECV: begin
                // A byte on the expiry cycle takes priority over the drop.
                if (rx_ready) begin
                    buf_wr        = 1'b1;
                    wr_idx        = byte_cnt;
                    byte_cnt_next = byte_cnt + 1'b1;
                    if (byte_cnt == CNT_BITS'(FRAME_BYTES - 1)) begin
                        state_next = ST_COMMIT;
                    end
                end else if (timer_expired) begin
                    drop          = 1'b1;
                    byte_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    timer_clear  = 1'b0;
                    timer_enable = 1'b1;
                end
            end
            ST_COMMIT: begin
                commit        = 1'b1;
                byte_cnt_next = '0;
                state_next    = ST_IDLE;
                if (rx_ready) begin
                    buf_wr        = 1'b1;
                    byte_cnt_next = CNT_BITS'(1);
                    state_next    = ST_RECV;
                end
            end
            default: begin
                byte_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // NOTE: the frame buffer has no reset; every byte is written before a commit can read it.
    always_ff @(posedge hash_clk) begin
        if (buf_wr) begin
            frame_buf[{wr_idx, 3'b000} +: 8] <= rx_data;
        end
    end

    // The copy sees the pre-edge buffer, so a byte landing in COMMIT cannot corrupt it.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            midstate      <= '0;
            data2         <= '0;
            work_valid    <= 1'b0;
            work_seq      <= '0;
            frame_dropped <= 1'b0;
        end else begin
            work_valid    <= commit;
            frame_dropped <= drop;
            if (commit) begin
                midstate <= frame_buf[WORK_BITS-1:0];
                data2    <= frame_buf[BUF_BITS-1:WORK_BITS];
                work_seq <= work_seq + 1'b1;
            end
        end
    end

endmodule
